// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit spacer state encoding.
package eth_pkg;

    localparam int ETH_MIN_FRAME_NO_FCS = 60;
    localparam int RMII_CYCLES_PER_BYTE = 4;
    localparam int ETH_IFG_BYTES        = 12;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PAD  = 2'd1,
        GAP  = 2'd2
    } eth_spacer_state_t;

endpackage

// File: rtl/eth_tx_spacer.sv
// Pads short transmit frames with zero bytes up to the Ethernet minimum and
// forces a fixed idle gap after every frame on a byte-wide AXI-Stream.
module eth_tx_spacer
    import eth_pkg::*;
#(
    parameter int MIN_BYTES  = ETH_MIN_FRAME_NO_FCS,
    parameter int GAP_CYCLES = ETH_IFG_BYTES * RMII_CYCLES_PER_BYTE
) (
    input  logic       clk,
    input  logic       sresetn,
    output logic       in_axis_tready,
    input  logic       in_axis_tvalid,
    input  logic       in_axis_tlast,
    input  logic [7:0] in_axis_tdata,
    input  logic       out_axis_tready,
    output logic       out_axis_tvalid,
    output logic       out_axis_tlast,
    output logic [7:0] out_axis_tdata
);

    localparam int CNT_W = $clog2(MIN_BYTES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_BYTES - 1);
    localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W + 1)'(MIN_BYTES);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    eth_spacer_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              reach_min;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              out_last_c;
    logic [7:0]        out_data_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Compared one bit wider so cnt+1 cannot wrap when cnt sits at its saturation value.
    assign reach_min = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= MIN_EXT;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q <= PASS;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = 8'h00;

        case (state_q)
            PASS: begin
                out_valid_c = in_axis_tvalid;
                in_ready_c  = out_axis_tready;
                out_data_c  = in_axis_tdata;
                out_last_c  = in_axis_tlast && reach_min;
                if (in_axis_tvalid && out_axis_tready) begin
                    cnt_d = sat_inc(cnt_q);
                    if (in_axis_tlast) begin
                        if (!reach_min) begin
                            state_d = PAD;
                        end else if (GAP_CYCLES == 0) begin
                            cnt_d = '0;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end

            PAD: begin
                out_valid_c = 1'b1;
                out_last_c  = (cnt_q == CNT_LAST);
                if (out_axis_tready) begin
                    cnt_d = sat_inc(cnt_q);
                    if (out_last_c) begin
                        if (GAP_CYCLES == 0) begin
                            state_d = PASS;
                            cnt_d   = '0;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_q == '0) begin
                    state_d = PASS;
                    cnt_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = PASS;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held, independent of state.
    assign in_axis_tready  = sresetn & in_ready_c;
    assign out_axis_tvalid = sresetn & out_valid_c;
    assign out_axis_tlast  = out_last_c;
    assign out_axis_tdata  = out_data_c;

endmodule

// File: tb/tb_eth_tx_spacer.sv
// Bench for eth_tx_spacer: default instance (60/48) and a zero-gap instance.
module tb_eth_tx_spacer;

    localparam int MIN_B = 60;
    localparam int GAP_B = 48;

    logic       clk = 1'b0;
    logic       sresetn = 1'b1;
    logic       in_tvalid [2];
    logic       in_tlast  [2];
    logic [7:0] in_tdata  [2];
    logic       in_tready [2];
    logic       out_tready[2];
    logic       out_tvalid[2];
    logic       out_tlast [2];
    logic [7:0] out_tdata [2];

    int checks = 0;
    int failures = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    eth_tx_spacer dut (
        .clk            (clk),
        .sresetn        (sresetn),
        .in_axis_tready (in_tready[0]),
        .in_axis_tvalid (in_tvalid[0]),
        .in_axis_tlast  (in_tlast[0]),
        .in_axis_tdata  (in_tdata[0]),
        .out_axis_tready(out_tready[0]),
        .out_axis_tvalid(out_tvalid[0]),
        .out_axis_tlast (out_tlast[0]),
        .out_axis_tdata (out_tdata[0])
    );

    eth_tx_spacer #(.GAP_CYCLES(0)) dut_nogap (
        .clk            (clk),
        .sresetn        (sresetn),
        .in_axis_tready (in_tready[1]),
        .in_axis_tvalid (in_tvalid[1]),
        .in_axis_tlast  (in_tlast[1]),
        .in_axis_tdata  (in_tdata[1]),
        .out_axis_tready(out_tready[1]),
        .out_axis_tvalid(out_tvalid[1]),
        .out_axis_tlast (out_tlast[1]),
        .out_axis_tdata (out_tdata[1])
    );

    // Drives one frame into instance k and scores every output beat.
    // pat 0 = bytes 1,2,3..., pat 1 = random bytes. Returns early after
    // abort_at output beats when abort_at is nonzero.
    task automatic run_frame(input int k, input int len, input int pat, input int rdy_pct,
                             input int stall_at, input int stall_len, input int abort_at,
                             input bit gap_chk, input string tag);
        logic [7:0] src[$];
        logic [8:0] e;
        logic [7:0] hold_d;
        logic       hold_l;
        int idx = 0, beats = 0, cyc = 0, stall = 0, gap = 0, exp_gap, exp_total;
        bit hs_in = 0, hs_out = 0, done = 0, stalled = 0, aborted = 0;
        exp_total = (len > MIN_B) ? len : MIN_B;
        exp_gap   = (k == 0) ? GAP_B : 0;
        for (int i = 0; i < len; i++) src.push_back(pat == 0 ? 8'(i + 1) : 8'($urandom_range(255)));
        sb.delete();
        while (!done) begin
            @(negedge clk);
            if (hs_in) idx++;
            if (idx < len) begin
                in_tvalid[k] = 1'b1;
                in_tdata[k]  = src[idx];
                in_tlast[k]  = (idx == len - 1);
            end else begin
                in_tvalid[k] = 1'b0;
                in_tdata[k]  = 8'h00;
                in_tlast[k]  = 1'b0;
            end
            if (stall > 0) begin
                out_tready[k] = 1'b0;
                stall--;
            end else begin
                out_tready[k] = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
            end
            #1;
            cyc++;
            hs_in  = in_tvalid[k] && in_tready[k];
            hs_out = out_tvalid[k] && out_tready[k];
            checks++;
            if (idx < len) begin
                if (in_tready[k] !== out_tready[k]) begin
                    failures++;
                    $display("FAIL %s_ready_mirror cyc=%0d got=%b exp=%b", tag, cyc, in_tready[k], out_tready[k]);
                end
            end else if (in_tready[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s_ready_pad cyc=%0d got=%b exp=0", tag, cyc, in_tready[k]);
            end
            if (stalled) begin
                checks++;
                if (out_tvalid[k] !== 1'b1 || out_tdata[k] !== hold_d || out_tlast[k] !== hold_l) begin
                    failures++;
                    $display("FAIL %s_stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", tag, cyc,
                             out_tvalid[k], out_tdata[k], out_tlast[k], hold_d, hold_l);
                end
            end
            stalled = out_tvalid[k] && !out_tready[k];
            hold_d  = out_tdata[k];
            hold_l  = out_tlast[k];
            if (hs_in) begin
                sb.push_back({src[idx], (idx == len - 1) && (len >= MIN_B)});
                if (idx == len - 1 && len < MIN_B)
                    for (int p = len; p < MIN_B; p++) sb.push_back({8'h00, p == MIN_B - 1});
            end
            if (hs_out) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_beat beat=%0d got=%h/%b exp=none", tag, beats, out_tdata[k], out_tlast[k]);
                end else begin
                    e = sb.pop_front();
                    if ({out_tdata[k], out_tlast[k]} !== e) begin
                        failures++;
                        $display("FAIL %s_beat%0d got=%h/%b exp=%h/%b", tag, beats,
                                 out_tdata[k], out_tlast[k], e[8:1], e[0]);
                    end
                end
                beats++;
                if (out_tlast[k] === 1'b1) done = 1;
                if (stall_at != 0 && beats == stall_at) stall = stall_len;
                if (abort_at != 0 && beats == abort_at) begin
                    done = 1;
                    aborted = 1;
                end
            end
            if (!done && cyc > 2000) begin
                failures++;
                $display("FAIL %s_timeout beats=%0d exp=%0d", tag, beats, exp_total);
                done = 1;
                aborted = 1;
            end
        end
        if (!aborted) begin
            checks++;
            if (beats != exp_total) begin
                failures++;
                $display("FAIL %s_beat_count got=%0d exp=%0d", tag, beats, exp_total);
            end
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL %s_missing_beats got=%0d exp=0", tag, sb.size());
            end
        end
        if (gap_chk && !aborted) begin
            done = 0;
            while (!done) begin
                @(negedge clk);
                in_tvalid[k]  = 1'b1;
                in_tdata[k]   = 8'hAA;
                in_tlast[k]   = 1'b0;
                out_tready[k] = 1'b1;
                #1;
                if (in_tready[k] === 1'b1) begin
                    in_tvalid[k] = 1'b0;
                    done = 1;
                end else begin
                    checks++;
                    if (out_tvalid[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_gap_valid cyc=%0d got=%b exp=0", tag, gap, out_tvalid[k]);
                    end
                    gap++;
                    if (gap > 500) done = 1;
                end
            end
            checks++;
            if (gap != exp_gap) begin
                failures++;
                $display("FAIL %s_gap_len got=%0d exp=%0d", tag, gap, exp_gap);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        sresetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_tvalid[k] = 1'b1;
            in_tdata[k] = 8'h11;
            in_tlast[k] = 1'b0;
            out_tready[k] = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (out_tvalid[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_valid%0d got=%b exp=0", k, out_tvalid[k]);
                end
                checks++;
                if (in_tready[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_ready%0d got=%b exp=0", k, in_tready[k]);
                end
            end
        end
        @(negedge clk);
        sresetn = 1'b1;
        in_tvalid[0] = 1'b0;
        in_tvalid[1] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_tready[k] !== 1'b1 || out_tvalid[k] !== 1'b0) begin
                failures++;
                $display("FAIL rst_release%0d got=%b/%b exp=1/0", k, in_tready[k], out_tvalid[k]);
            end
        end
    endtask

    task automatic test_short_frame();
        run_frame(0, 8, 0, 100, 0, 0, 0, 1, "short8");
    endtask

    task automatic test_min_frame();
        run_frame(0, 60, 1, 100, 0, 0, 0, 1, "min60");
    endtask

    task automatic test_long_stalled();
        run_frame(0, 100, 1, 50, 0, 0, 0, 1, "long100");
    endtask

    task automatic test_back_to_back();
        run_frame(1, 1, 1, 100, 0, 0, 0, 0, "b2b_first");
        run_frame(1, 5, 1, 100, 0, 0, 0, 1, "b2b_second");
    endtask

    task automatic test_reset_mid_pad();
        run_frame(0, 8, 0, 100, 0, 0, 20, 0, "pre_rst");
        @(negedge clk);
        sresetn = 1'b0;
        in_tvalid[0] = 1'b1;
        in_tdata[0] = 8'h33;
        out_tready[0] = 1'b1;
        #1;
        checks++;
        if (out_tvalid[0] !== 1'b0 || in_tready[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_pad_immediate got=%b/%b exp=0/0", out_tvalid[0], in_tready[0]);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_tvalid[0] !== 1'b0 || in_tready[0] !== 1'b0) begin
                failures++;
                $display("FAIL rst_pad_hold got=%b/%b exp=0/0", out_tvalid[0], in_tready[0]);
            end
        end
        @(negedge clk);
        sresetn = 1'b1;
        in_tvalid[0] = 1'b0;
        run_frame(0, 60, 1, 100, 0, 0, 0, 1, "post_rst60");
        run_frame(0, 8, 1, 100, 0, 0, 0, 1, "post_rst8");
    endtask

    task automatic test_pad_stall();
        run_frame(0, 8, 0, 100, 30, 10, 0, 1, "pad_stall");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_tvalid[k] = 1'b0;
            in_tlast[k] = 1'b0;
            in_tdata[k] = 8'h00;
            out_tready[k] = 1'b0;
        end
        test_reset();
        test_short_frame();
        test_min_frame();
        test_long_stalled();
        test_back_to_back();
        test_reset_mid_pad();
        test_pad_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_tx_spacer.md
# eth_tx_spacer

Transmit-side frame conditioner between the packet buffer and `rmii_to_axis`. It pads frames shorter than the Ethernet minimum with zero bytes and enforces a fixed idle interframe gap after every frame. Output is a byte-wide AXI-Stream in the same format as the input, so the PHY stage receives only legal, correctly spaced frames.

## Interface
- `MIN_BYTES`, 60: minimum frame length in bytes, counted from the first destination-MAC byte up to, but not including, the FCS. Must be ≥ 1.
- `GAP_CYCLES`, 48: idle `clk` cycles forced after each output `tlast` beat. 48 = 12 byte times × 4 cycles/byte at RMII 100M. 0 is legal.
- `clk`, in, 1: single clock for the whole block.
- `sresetn`, in, 1: reset; asynchronous, active-low.
- `in_axis_tready`, out, 1: input ready.
- `in_axis_tvalid`, in, 1: input valid.
- `in_axis_tlast`, in, 1: last byte of the input frame.
- `in_axis_tdata`, in, 8: input byte.
- `out_axis_tready`, in, 1: output ready.
- `out_axis_tvalid`, out, 1: output valid.
- `out_axis_tlast`, out, 1: last byte of the output frame (padded if required).
- `out_axis_tdata`, out, 8: output byte.

## Operation
- States:
  - PASS: forwarding input bytes.
  - PAD: emitting zero bytes.
  - GAP: idle.
- Byte counter `cnt`:
  - Width `$clog2(MIN_BYTES+1)`.
  - Counts output beats of the current frame; saturates at `MIN_BYTES`.
  - Cleared when entering PASS.
- PASS:
  - `out_tvalid = in_tvalid`, `in_tready = out_tready`, `out_tdata = in_tdata`.
  - `out_tlast = in_tlast && (cnt+1 >= MIN_BYTES)`.
  - On a handshake, `cnt` increments (saturating).
  - A handshake with `in_tlast` and `cnt+1 >= MIN_BYTES` → GAP.
  - A handshake with `in_tlast` and `cnt+1 < MIN_BYTES` → PAD. That beat goes out with `out_tlast = 0`.
- PAD:
  - `in_tready = 0`, `out_tvalid = 1`, `out_tdata = 8'h00`.
  - `out_tlast = (cnt == MIN_BYTES-1)`.
  - `cnt` increments on each handshake; the `tlast` handshake → GAP.
- GAP:
  - `in_tready = 0`, `out_tvalid = 0`.
  - Gap counter loads `GAP_CYCLES-1` on entry and decrements once per cycle.
  - → PASS when it reads 0.
  - If `GAP_CYCLES == 0`, the `tlast` handshake goes straight to PASS and GAP is never entered.
- Input underflow mid-frame (`in_tvalid` low in PASS) produces an output bubble. This is permitted; the upstream packet FIFO guarantees whole frames.
- Frames at or above `MIN_BYTES` pass unmodified, including frames longer than the counter range (the counter saturates).
- No data checking; `tdata` is never altered in PASS.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State = PASS, `cnt = 0`, gap counter = 0.
  - `out_axis_tvalid = 0` and `in_axis_tready = 0` while `sresetn` is low (outputs gated).
  - `out_tlast` and `out_tdata` are don't-care while `out_tvalid = 0`.
- Reset mid-PAD or mid-GAP abandons the frame or gap. The first cycle after release is PASS with `cnt = 0`.
- Latency in PASS: 0 cycles (combinational path `in`→`out`, `out_tready`→`in_tready`).
- Registered outputs in PAD/GAP: state change takes effect the cycle after the triggering handshake.
- Valid must not drop once asserted:
  - In PAD, `out_tvalid` is held high until the handshake.
  - In PASS, validity follows input, which obeys AXIS.
- Gap length: exactly `GAP_CYCLES` cycles with `out_tvalid = 0`, measured from the cycle after the output `tlast` handshake to the first cycle `in_tready` can be 1.
- Frame of `N < MIN_BYTES` bytes:
  - Exactly `MIN_BYTES` output beats; the last `MIN_BYTES-N` are zero.
  - With `out_tready` high, the padding takes `MIN_BYTES-N` cycles.

## Structure
- `eth_pkg` holds:
  - The state enum `eth_spacer_state_t` {PASS, PAD, GAP}.
  - Constants `ETH_MIN_FRAME_NO_FCS = 60` and `RMII_CYCLES_PER_BYTE = 4`, which set the parameter defaults.
- No sub-module. The state machine and two counters are all in one module.

## Test plan
- 8-byte frame 0x01..0x08, `out_tready = 1`: output is 0x01..0x08 then 52 bytes of 0x00, `tlast` on beat 60 only. Then 48 cycles with `tvalid = 0`, then `in_tready = 1`.
- 60-byte frame: all 60 bytes pass unchanged, `tlast` on byte 60, no pad, 48-cycle gap.
- 100-byte frame with random `out_tready` deassertion (50%): data is bit-exact, `in_tready` mirrors `out_tready`, `tvalid` is stable while stalled, and `tlast` appears only on byte 100.
- 1-byte frame, then an immediate second frame with `GAP_CYCLES = 0`: 60 beats, then the second frame's first byte is accepted the cycle after the padded `tlast` handshake.
- Assert `sresetn` low during PAD (beat 20), release after 3 cycles: `out_tvalid` goes to 0 immediately and `in_tready` goes to 0. After release, a new 60-byte frame passes with no residual pad or gap.
- PAD with `out_tready` held low for 10 cycles mid-pad: `out_tvalid` stays 1, `tdata` stays 0x00, and the total beat count is still `MIN_BYTES`.
